// File: rtl/ksz_bus_responder.sv
// ksz_bus_responder: slave side of a KSZ-style multiplexed address/data bus.
// An address phase (CMD=1 with WRN low) arms exactly one data access
// (write or read) to a 128 x 16-bit register file. A read-only CHIP_ID sits
// at offset 8'hC0 in the low halfword.
//
// Strobe semantics: RDN and WRN are active-low, level-sampled on every
// rising clk40m edge. A phase is "accepted" when its strobe is seen rising
// (low one cycle, high the next). SD is driven by this block only while an
// armed or active read has RDN low and WRN high. This enable is
// combinational from RDN, so data is on the bus in the same cycle RDN falls.
// RDN and WRN low together is a protocol error: the bus is released, the
// access is abandoned and bus_err is set.
`timescale 1ns/1ps
module ksz_bus_responder #(
  parameter logic [15:0] CHIP_ID = 16'h8872
) (
  input  logic        clk40m,
  input  logic        reset,
  input  logic        CMD,
  input  logic        RDN,
  input  logic        WRN,
  inout  wire  [15:0] SD,
  output logic        acc_wr,
  output logic        acc_rd,
  output logic [7:0]  acc_addr,
  output logic [3:0]  acc_be,
  output logic        bus_err,
  input  logic        err_clr,
  input  logic [6:0]  dbg_idx,
  output logic [15:0] dbg_data,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    ARMED = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] mem [128];
  logic [5:0]  cap_off;
  logic [3:0]  cap_be;
  logic [15:0] wdata;
  logic [15:0] rd_q;
  logic        addr_valid;

  logic        both_low;
  logic        idle_data;
  logic        be_ok;
  logic        addr_bad;
  logic        err_set;
  logic        cap_half;
  logic [6:0]  pf_idx;
  logic [15:0] pf_data;
  logic        wr_half;
  logic [6:0]  wr_idx;
  logic        commit;
  logic        wr_ignore;
  logic        sd_oe;

  // Only single bytes or aligned halfwords are legal lane patterns.
  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Decode of protocol errors, file indices, prefetch source and bus enable.
  always_comb begin
    both_low  = !RDN && !WRN;
    idle_data = (state == IDLE) && !CMD && (!RDN || !WRN);
    be_ok     = be_legal(cap_be);
    addr_bad  = (state == ADDR) && WRN && !be_ok;
    err_set   = both_low || idle_data || addr_bad;
    cap_half  = |cap_be[3:2];
    pf_idx    = {cap_off, cap_half};
    pf_data   = (cap_off == 6'h30 && !cap_half) ? CHIP_ID : mem[pf_idx];
    wr_half   = |acc_be[3:2];
    wr_idx    = {acc_addr[7:2], wr_half};
    commit    = (state == WDATA) && WRN && addr_valid;
    wr_ignore = (acc_addr == 8'hC0) && !wr_half;
    sd_oe     = addr_valid && ((state == ARMED) || (state == RDATA)) && !RDN && WRN;
    dbg_data  = mem[dbg_idx];
    fsm_state = state;
  end

  assign SD = sd_oe ? rd_q : 16'hzzzz;

  // Bus FSM: address capture, one armed access, data capture and pulses.
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cap_off    <= '0;
      cap_be     <= '0;
      wdata      <= '0;
      rd_q       <= '0;
      addr_valid <= 1'b0;
      acc_addr   <= '0;
      acc_be     <= '0;
      acc_wr     <= 1'b0;
      acc_rd     <= 1'b0;
    end else begin
      acc_wr <= 1'b0;
      acc_rd <= 1'b0;
      if (both_low) begin
        state      <= IDLE;
        addr_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (CMD && !WRN) begin
              state   <= ADDR;
              cap_off <= SD[7:2];
              cap_be  <= SD[15:12];
            end
          end
          ADDR: begin
            if (!WRN) begin
              if (CMD) begin
                cap_off <= SD[7:2];
                cap_be  <= SD[15:12];
              end
            end else if (be_ok) begin
              state      <= ARMED;
              addr_valid <= 1'b1;
              acc_addr   <= {cap_off, 2'b00};
              acc_be     <= cap_be;
              rd_q       <= pf_data;
            end else begin
              state <= IDLE;
            end
          end
          ARMED: begin
            if (CMD && !WRN) begin
              // A fresh address phase replaces the pending one.
              state      <= ADDR;
              addr_valid <= 1'b0;
              cap_off    <= SD[7:2];
              cap_be     <= SD[15:12];
            end else if (!CMD && !WRN) begin
              state <= WDATA;
              wdata <= SD;
            end else if (!CMD && !RDN) begin
              state <= RDATA;
            end
          end
          WDATA: begin
            if (!WRN) begin
              wdata <= SD;
            end else begin
              state      <= IDLE;
              addr_valid <= 1'b0;
              acc_wr     <= 1'b1;
            end
          end
          RDATA: begin
            if (RDN) begin
              state      <= IDLE;
              addr_valid <= 1'b0;
              acc_rd     <= 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            addr_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // Register file: byte-lane commit on the write strobe's rising edge.
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (commit && !wr_ignore) begin
      if (wr_half ? acc_be[2] : acc_be[0]) mem[wr_idx][7:0]  <= wdata[7:0];
      if (wr_half ? acc_be[3] : acc_be[1]) mem[wr_idx][15:8] <= wdata[15:8];
    end
  end

  // Sticky error flag; a new error wins over a same-cycle clear.
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) bus_err <= 1'b0;
    else        bus_err <= err_set || (bus_err && !err_clr);
  end

endmodule

// File: tb/tb_ksz_bus_responder.sv
// Directed bench for ksz_bus_responder with a byte-addressed reference model.
`timescale 1ns/1ps
module tb_ksz_bus_responder;

  logic        clk40m  = 1'b0;
  logic        reset   = 1'b0;
  logic        CMD     = 1'b0;
  logic        RDN     = 1'b1;
  logic        WRN     = 1'b1;
  logic        err_clr = 1'b0;
  logic [6:0]  dbg_idx = '0;
  logic        acc_wr, acc_rd, bus_err;
  logic [7:0]  acc_addr;
  logic [3:0]  acc_be;
  logic [15:0] dbg_data;
  logic [2:0]  fsm_state;
  wire  [15:0] SD;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_sd = '0;

  assign SD = tb_oe ? tb_sd : 16'hzzzz;

  ksz_bus_responder #(.CHIP_ID(16'h8872)) dut (
    .clk40m(clk40m), .reset(reset), .CMD(CMD), .RDN(RDN), .WRN(WRN), .SD(SD),
    .acc_wr(acc_wr), .acc_rd(acc_rd), .acc_addr(acc_addr), .acc_be(acc_be),
    .bus_err(bus_err), .err_clr(err_clr), .dbg_idx(dbg_idx),
    .dbg_data(dbg_data), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk40m = ~clk40m;

  // ---------------- reference model ----------------
  // The file is viewed as 256 bytes: byte address = {offset[7:2], lane}.
  logic [7:0]  m_bytes [256];
  logic [7:0]  m_addr;
  logic [3:0]  m_be;
  logic        m_err, m_armed;
  int          m_wr, m_rd;

  // Scoreboard: expected read words while RDN is low.
  logic [15:0] exp_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cnt_wr = 0, cnt_rd = 0;
  logic        prev_wr = 1'b0, prev_rd = 1'b0;
  logic        chk_en = 1'b0, rd_chk = 1'b0, z_chk = 1'b0;
  logic [15:0] z_val = '0;

  function automatic logic [15:0] m_half(input logic [6:0] h);
    return {m_bytes[{h, 1'b1}], m_bytes[{h, 1'b0}]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_bytes[i] = 8'h00;
    m_addr = '0; m_be = '0; m_err = 1'b0; m_armed = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
    n_checks++;
    if (act === bad) begin
      n_errors++;
      $display("FAIL %s: got %h, bus still driven (expected released, not %h) at %0t", name, act, bad, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk40m) begin
    if (acc_wr) begin
      cnt_wr++;
      check("acc_wr_one_cycle", {31'd0, prev_wr}, 32'd0);
    end
    if (acc_rd) begin
      cnt_rd++;
      check("acc_rd_one_cycle", {31'd0, prev_rd}, 32'd0);
    end
    prev_wr = acc_wr;
    prev_rd = acc_rd;
    if (chk_en) begin
      check("dbg_data", {16'd0, dbg_data}, {16'd0, m_half(dbg_idx)});
      check("acc_addr", {24'd0, acc_addr}, {24'd0, m_addr});
      check("acc_be",   {28'd0, acc_be},   {28'd0, m_be});
      check("bus_err",  {31'd0, bus_err},  {31'd0, m_err});
    end
    if (rd_chk) begin
      if (exp_q.size() == 0) check("sd_read_queue", 32'd0, 32'd1);
      else                   check("sd_read", {16'd0, SD}, {16'd0, exp_q[0]});
    end
    if (z_chk) check_ne("sd_released", {16'd0, SD}, {16'd0, z_val});
  end

  // ---------------- driver tasks ----------------
  task automatic start_cycle();
    @(posedge clk40m); #1;
  endtask

  task automatic addr_phase(input logic [15:0] a);
    logic [3:0] be;
    start_cycle(); CMD = 1'b1; WRN = 1'b0; tb_oe = 1'b1; tb_sd = a;
    start_cycle();
    start_cycle(); WRN = 1'b1; CMD = 1'b0; tb_oe = 1'b0;
    start_cycle();
    be = a[15:12];
    if (be == 4'b0011 || be == 4'b1100 || be == 4'b0001 ||
        be == 4'b0010 || be == 4'b0100 || be == 4'b1000) begin
      m_addr = {a[7:2], 2'b00}; m_be = be; m_armed = 1'b1;
    end else begin
      m_err = 1'b1; m_armed = 1'b0;
    end
  endtask

  task automatic write_data(input logic [15:0] d);
    start_cycle(); CMD = 1'b0; WRN = 1'b0; tb_oe = 1'b1; tb_sd = d;
    start_cycle();
    start_cycle(); WRN = 1'b1; tb_oe = 1'b0;
    start_cycle();
    if (m_armed) begin
      if (!(m_addr == 8'hC0 && !(|m_be[3:2])))
        for (int i = 0; i < 4; i++)
          if (m_be[i]) m_bytes[{m_addr[7:2], 2'(i)}] = i[0] ? d[15:8] : d[7:0];
      m_wr++;
      m_armed = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic read_data(input logic [15:0] exp);
    start_cycle(); CMD = 1'b0; RDN = 1'b0; exp_q.push_back(exp); rd_chk = 1'b1;
    start_cycle();
    start_cycle(); RDN = 1'b1; rd_chk = 1'b0; exp_q.delete(0);
    z_val = exp; z_chk = (exp != 16'h0000);
    start_cycle(); z_chk = 1'b0;
    m_rd++;
    m_armed = 1'b0;
  endtask

  // Data strobe with no armed address (optionally with err_clr in the same cycle).
  task automatic stray_strobe(input logic use_rd, input logic clr);
    start_cycle(); CMD = 1'b0; err_clr = clr;
    if (use_rd) RDN = 1'b0;
    else begin WRN = 1'b0; tb_oe = 1'b1; tb_sd = 16'h9999; end
    start_cycle(); RDN = 1'b1; WRN = 1'b1; tb_oe = 1'b0; err_clr = 1'b0;
    start_cycle();
    m_err = 1'b1;
  endtask

  task automatic both_low_strobe();
    start_cycle(); CMD = 1'b0; RDN = 1'b0; WRN = 1'b0; tb_oe = 1'b1; tb_sd = 16'hDEAD;
    start_cycle(); RDN = 1'b1; WRN = 1'b1; tb_oe = 1'b0;
    start_cycle();
    m_err = 1'b1; m_armed = 1'b0;
  endtask

  task automatic clear_err();
    start_cycle(); err_clr = 1'b1;
    start_cycle(); err_clr = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic settle(input int n);
    logic [6:0] picks [4];
    picks[0] = 7'd8; picks[1] = 7'd9; picks[2] = 7'd96; picks[3] = 7'd97;
    chk_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      start_cycle();
      if (i[0]) dbg_idx = 7'($urandom_range(0, 127));
      else      dbg_idx = picks[$urandom_range(0, 3)];
      @(negedge clk40m);
    end
    #1 chk_en = 1'b0;
    check("acc_wr_count", cnt_wr, m_wr);
    check("acc_rd_count", cnt_rd, m_rd);
  endtask

  task automatic lit_idx(input string name, input logic [6:0] h, input logic [15:0] exp);
    start_cycle(); dbg_idx = h;
    @(negedge clk40m);
    check(name, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  task automatic check_reset_outputs(input string tag, input logic [15:0] drv);
    check({tag, "_fsm_idle"}, {29'd0, fsm_state}, 32'd0);
    check({tag, "_acc_wr"},   {31'd0, acc_wr},    32'd0);
    check({tag, "_acc_rd"},   {31'd0, acc_rd},    32'd0);
    check({tag, "_acc_addr"}, {24'd0, acc_addr},  32'd0);
    check({tag, "_acc_be"},   {28'd0, acc_be},    32'd0);
    check({tag, "_bus_err"},  {31'd0, bus_err},   32'd0);
    check_ne({tag, "_sd_hiz"}, {16'd0, SD}, {16'd0, drv});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    m_wr = 0; m_rd = 0;
    dbg_idx = 7'd0;
    #3;
    check_reset_outputs("por", 16'h8872);
    check("por_dbg0", {16'd0, dbg_data}, 32'd0);
    start_cycle(); reset = 1'b1;
    settle(4);

    // Word write to offset 0x10, low halfword.
    addr_phase(16'h3010); write_data(16'hBEEF); settle(4);
    lit_idx("word_write_idx8", 7'd8, 16'hBEEF);

    // Byte write, lane 3 only.
    addr_phase(16'h8012); write_data(16'h5A00); settle(4);
    lit_idx("byte_write_idx9", 7'd9, 16'h5A00);
    lit_idx("byte_write_idx8", 7'd8, 16'hBEEF);

    // Upper halfword write then read back.
    addr_phase(16'hC012); write_data(16'h1234); settle(3);
    lit_idx("hi_write_idx9", 7'd9, 16'h1234);
    addr_phase(16'hC012); read_data(16'h1234); settle(4);

    // Chip ID read, ignored write, read again.
    addr_phase(16'h30C0); read_data(16'h8872); settle(2);
    addr_phase(16'h30C0); write_data(16'h0000); settle(2);
    addr_phase(16'h30C0); read_data(16'h8872); settle(3);
    lit_idx("chip_id_file_idx96", 7'd96, 16'h0000);

    // Read immediately after write returns the new value.
    addr_phase(16'h3010); write_data(16'hCAFE);
    addr_phase(16'h3010); read_data(16'hCAFE); settle(3);

    // Second address phase replaces the pending one.
    addr_phase(16'h3010); addr_phase(16'h8012); write_data(16'h7700); settle(3);
    lit_idx("readdr_idx9", 7'd9, 16'h7734);
    lit_idx("readdr_idx8", 7'd8, 16'hCAFE);

    // Illegal byte enables, stray data phases, both strobes low.
    addr_phase(16'hA010); settle(2);
    check("illegal_be_err", {31'd0, bus_err}, 32'd1);
    stray_strobe(1'b0, 1'b0); settle(2);
    lit_idx("stray_write_idx8", 7'd8, 16'hCAFE);
    clear_err(); settle(2);
    check("err_clr", {31'd0, bus_err}, 32'd0);
    addr_phase(16'h3010); both_low_strobe(); settle(2);
    lit_idx("both_low_idx8", 7'd8, 16'hCAFE);
    check("both_low_err", {31'd0, bus_err}, 32'd1);
    stray_strobe(1'b0, 1'b0); settle(2);
    clear_err();
    stray_strobe(1'b1, 1'b0); settle(2);
    stray_strobe(1'b0, 1'b1); settle(2);
    check("err_and_clr_same_cycle", {31'd0, bus_err}, 32'd1);
    clear_err(); settle(2);

    // Reset during a read: bus released at once, no acc_rd.
    addr_phase(16'h3010);
    start_cycle(); CMD = 1'b0; RDN = 1'b0;
    start_cycle(); #2;
    check("sd_before_reset", {16'd0, SD}, {16'd0, 16'hCAFE});
    reset = 1'b0; #1;
    check_reset_outputs("rst_rd", 16'hCAFE);
    RDN = 1'b1;
    start_cycle(); start_cycle(); reset = 1'b1;
    model_reset(); settle(3);

    // Reset during a write: no commit, file cleared.
    addr_phase(16'h3010); write_data(16'h1357); settle(2);
    lit_idx("pre_reset_idx8", 7'd8, 16'h1357);
    addr_phase(16'h3010);
    start_cycle(); CMD = 1'b0; WRN = 1'b0; tb_oe = 1'b1; tb_sd = 16'h2468;
    start_cycle(); #2;
    reset = 1'b0; #1;
    check_reset_outputs("rst_wr", 16'h1357);
    check("rst_wr_file_cleared", {16'd0, dbg_data}, 32'd0);
    WRN = 1'b1; tb_oe = 1'b0;
    start_cycle(); start_cycle(); reset = 1'b1;
    model_reset(); settle(3);
    lit_idx("no_commit_idx8", 7'd8, 16'h0000);

    // Normal operation after reset.
    addr_phase(16'h3010); write_data(16'h0F0F);
    addr_phase(16'h3010); read_data(16'h0F0F); settle(4);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
